// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the two-channel input conditioner.
// Debounce FSM states and parameter defaults live here.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    LOW,
    CHK_HIGH,
    HIGH,
    CHK_LOW
  } deb_state_t;

  localparam int N_DEF             = 4;
  localparam int STABLE_CYCLES_DEF = 10;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioning channel: 2-flop synchroniser, debounce FSM,
// and registered one-cycle rise/fall pulses.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int N             = N_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic checking
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2**N) - 1) begin : g_bad
    $error("STABLE_CYCLES out of range for counter width N");
  end

  localparam logic [N-1:0] LAST = N'(STABLE_CYCLES - 1);

  logic         s1;
  logic         s2;
  deb_state_t   state_q;
  deb_state_t   state_d;
  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic         rise_d;
  logic         fall_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // A CHK_* state falls back on the first sample that disagrees.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s2) begin
          state_d = CHK_HIGH;
          cnt_d   = '0;
        end
      end
      CHK_HIGH: begin
        if (!s2) begin
          state_d = LOW;
        end else if (cnt_q == LAST) begin
          state_d = HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_d = CHK_LOW;
          cnt_d   = '0;
        end
      end
      CHK_LOW: begin
        if (s2) begin
          state_d = HIGH;
        end else if (cnt_q == LAST) begin
          state_d = LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = LOW;
    endcase
  end

  assign level    = (state_q == HIGH) || (state_q == CHK_LOW);
  assign checking = (state_q == CHK_HIGH) || (state_q == CHK_LOW);

endmodule

// File: rtl/input_conditioner.sv
// Two independent debounced channels driving top.A / top.B,
// with a combined busy flag.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N             = N_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic A,
  output logic B,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic busy
);

  logic a_chk;
  logic b_chk;

  debounce_channel #(
    .N(N),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_a (
    .clk     (clk),
    .rst     (rst),
    .raw     (a_raw),
    .level   (A),
    .rise    (a_rise),
    .fall    (a_fall),
    .checking(a_chk)
  );

  debounce_channel #(
    .N(N),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_b (
    .clk     (clk),
    .rst     (rst),
    .raw     (b_raw),
    .level   (B),
    .rise    (b_rise),
    .fall    (b_fall),
    .checking(b_chk)
  );

  assign busy = a_chk | b_chk;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage that sits directly upstream of `top` and drives its `A` and `B` inputs. Each of two raw, asynchronous inputs is synchronised, debounced, and published as a clean level. One-cycle rise/fall event pulses are generated alongside each clean level. `top` only ever sees levels that have been stable for a programmed number of cycles.

## Interface
- `N`, 4, width of each debounce counter
- `STABLE_CYCLES`, 10, consecutive synchronised cycles a new level must hold before it is accepted; legal range 1 .. 2**N-1, elaboration-time check
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `a_raw`  input  1  raw asynchronous channel A
- `b_raw`  input  1  raw asynchronous channel B
- `A`  output  1  debounced level of channel A; feeds `top.A`
- `B`  output  1  debounced level of channel B; feeds `top.B`
- `a_rise`, `a_fall`  output  1 each  one-cycle pulses on accepted A transitions
- `b_rise`, `b_fall`  output  1 each  one-cycle pulses on accepted B transitions
- `busy`  output  1  high while either channel is qualifying a candidate change

## Operation
- Per channel: 2-flop synchroniser (`s1`, `s2`) feeding a 4-state FSM plus N-bit counter `cnt`.
- States: `LOW`, `CHK_HIGH`, `HIGH`, `CHK_LOW`. The clean output is 1 in `HIGH` and `CHK_LOW`, and 0 otherwise.
- `LOW`: `s2==1` -> `CHK_HIGH`, `cnt<=0`; else stay.
- `CHK_HIGH`:
  - `s2==0` -> `LOW` (glitch rejected; no output change, no pulse).
  - `s2==1` and `cnt==STABLE_CYCLES-1` -> `HIGH`; clean output <=1; rise pulse <=1.
  - Otherwise `cnt<=cnt+1`.
- `HIGH` / `CHK_LOW`: mirror image of the above, with a fall pulse.
- Pulses are registered and high for exactly one cycle, in the same cycle the clean level first changes.
- `cnt` never exceeds `STABLE_CYCLES-1`; no wrap-around is possible.
- The two channels are fully independent. Simultaneous changes on both channels qualify in parallel and may pulse in the same cycle.
- `busy` = (A channel in a `CHK_*` state) OR (B channel in a `CHK_*` state), taken combinationally from the state registers.

## Timing
- Reset (`rst` low, asynchronous): `s1`, `s2`, `cnt` <= 0; FSM <= `LOW`.
- Reset values of outputs: `A`=0, `B`=0, all pulses 0, `busy`=0.
- Reset asserted mid-qualification aborts the qualification immediately; no pulse is emitted.
- After `rst` deasserts, a raw input already at 1 is accepted through the normal path. The output rises `STABLE_CYCLES+2` edges later, with a rise pulse.
- Latency: a raw change sampled at edge k appears on the clean output and pulse after edge k+2+`STABLE_CYCLES` (12 cycles at the defaults).
- A raw pulse that is synchronised-high for at most `STABLE_CYCLES` cycles is rejected entirely.
- `STABLE_CYCLES=1`: the transition is accepted on the first `CHK_*` cycle, giving a total latency of 3.

## Structure
- Package `input_conditioner_pkg`:
  - typedef enum `deb_state_t` {`LOW`, `CHK_HIGH`, `HIGH`, `CHK_LOW`}.
  - Localparam default for `STABLE_CYCLES`.
- Sub-module `debounce_channel` (parameters `N`, `STABLE_CYCLES`; ports `clk`, `rst`, `raw`, `level`, `rise`, `fall`, `checking`) is instantiated twice.
- The top level is wiring plus the `busy` OR only.

## Test plan
- Reset: hold `rst`=0 with `a_raw`=`b_raw`=1 -> `A`=`B`=0, no pulses, `busy`=0. Release -> `A` and `B` rise after exactly 12 edges, each with one rise pulse.
- Clean step: `a_raw` 0->1 at edge 20 -> `busy`=1 from edge 22; `A`=1 and `a_rise`=1 at edge 32; `a_rise`=0 at edge 33; `busy`=0.
- Glitch rejection: `b_raw` high for 5 cycles then low -> `B` stays 0, no `b_rise`, `busy` returns to 0. Repeat with 10 high cycles -> still rejected.
- Bounce: `a_raw` toggles 1,0,1,1,... with the final high held 15 cycles -> exactly one `a_rise`, 12 edges after the last rising sample; no `a_fall`.
- Simultaneous events: `a_raw` 1->0 and `b_raw` 0->1 on the same edge -> `a_fall` and `b_rise` in the same cycle. In a downstream `top` instance, `Q` stays 1 throughout.
- Reset mid-qualification: assert `rst` 6 cycles into `CHK_HIGH` -> outputs 0 immediately, no pulse. `STABLE_CYCLES=1` build -> 3-edge latency.
